hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core; the stalling and flushing counterpart to the EX-stage forwarding logic. It resolves the hazards forwarding cannot cover: load-use dependencies, HI/LO reads behind a multi-cycle mult/div, and wrong-path instructions after a taken branch or jump. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls. A down-counter tracks the in-flight mult/div.

---
 rtl/hazard_stall_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush control for the 5-stage MIPS pipeline.
// Covers load-use, HI/LO reads behind an in-flight mult/div, and
// wrong-path squash after a taken branch/jump resolved in EX.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFIDRegRs,
    input  logic [4:0]       IFIDRegRt,
    input  logic             IDUsesRt,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXRegRt,
    input  logic             IDMulDiv,
    input  logic             IDReadsHiLo,
    input  logic             EXBranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned MD_CNT_W = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [MD_CNT_W-1:0] r_cnt;

    logic w_ld_use;
    logic w_md_use;
    logic w_stall;
    logic w_issue;

    // Hazard detection from the ID/EX operands and the mult/div tracker
    always_comb begin
        w_ld_use = IDEXMemRead && (IDEXRegRt != 5'd0) &&
                   ((IDEXRegRt == IFIDRegRs) || (IDUsesRt && (IDEXRegRt == IFIDRegRt)));
        w_md_use = MulDivBusy && (IDReadsHiLo || IDMulDiv);
        w_stall  = (w_ld_use || w_md_use) && !EXBranchTaken;
        w_issue  = IDMulDiv && !w_stall && !EXBranchTaken;
    end

    assign MulDivBusy = (r_state == ST_MDWAIT);

    // Mult/div latency tracker: RUN while idle, MDWAIT while a result is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (w_issue) begin
            r_state <= ST_MDWAIT;
            r_cnt   <= MD_CNT_W'(MULDIV_LAT);
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - MD_CNT_W'(1);
            r_state <= (r_cnt == MD_CNT_W'(1)) ? ST_RUN : ST_MDWAIT;
        end
    end

    // Pipeline-register controls: reset, then flush, then stall, then normal flow
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (EXBranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (w_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of stall cycles, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver pushes expected
// responses from a cycle-indexed reference model, a monitor pops and compares.
module tb_hazard_stall_ctrl;

    localparam int unsigned LAT   = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       IFIDRegRs, IFIDRegRt, IDEXRegRt;
    logic             IDUsesRt, IDEXMemRead, IDMulDiv, IDReadsHiLo, EXBranchTaken;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy;
    logic [CNT_W-1:0] StallCount;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFIDRegRs(IFIDRegRs), .IFIDRegRt(IFIDRegRt), .IDUsesRt(IDUsesRt),
        .IDEXMemRead(IDEXMemRead), .IDEXRegRt(IDEXRegRt),
        .IDMulDiv(IDMulDiv), .IDReadsHiLo(IDReadsHiLo), .EXBranchTaken(EXBranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXBubble(IDEXBubble), .MulDivBusy(MulDivBusy), .StallCount(StallCount)
    );

    typedef struct packed {
        logic             pcw;
        logic             ifidw;
        logic             flush;
        logic             bubble;
        logic             busy;
        logic [CNT_W-1:0] sc;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_last = -1;   // last cycle index during which a mult/div result is pending
    int   sc_model  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, c, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PCWrite",    32'(PCWrite),    32'(e.pcw),    e.cyc);
            chk("IFIDWrite",  32'(IFIDWrite),  32'(e.ifidw),  e.cyc);
            chk("IFIDFlush",  32'(IFIDFlush),  32'(e.flush),  e.cyc);
            chk("IDEXBubble", 32'(IDEXBubble), 32'(e.bubble), e.cyc);
            chk("MulDivBusy", 32'(MulDivBusy), 32'(e.busy),   e.cyc);
            chk("StallCount", 32'(StallCount), 32'(e.sc),     e.cyc);
        end
    end

    // One pipeline cycle: apply inputs, predict the response, advance the model
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic memrd, input logic [4:0] ldrt,
                        input logic md, input logic hilo, input logic br);
        exp_t e;
        bit   busy, ld_use, md_use, stall;
        @(posedge clk);
        #1;
        rst = r; IFIDRegRs = rs; IFIDRegRt = rt; IDUsesRt = uses_rt;
        IDEXMemRead = memrd; IDEXRegRt = ldrt; IDMulDiv = md;
        IDReadsHiLo = hilo; EXBranchTaken = br;
        e.cyc = cyc;
        if (r) begin
            busy_last = -1;
            sc_model  = 0;
            e.pcw = 1'b0; e.ifidw = 1'b0; e.flush = 1'b1; e.bubble = 1'b1;
            e.busy = 1'b0; e.sc = '0;
        end else begin
            busy   = (cyc <= busy_last);
            ld_use = memrd && (ldrt != 0) && ((ldrt == rs) || (uses_rt && (ldrt == rt)));
            md_use = busy && (hilo || md);
            stall  = (ld_use || md_use) && !br;
            e.busy   = busy;
            e.sc     = CNT_W'(sc_model);
            e.pcw    = !stall;
            e.ifidw  = !stall;
            e.flush  = br;
            e.bubble = br || stall;
`ifdef HAZARD_PERF_EN
            if (stall && sc_model < (1 << CNT_W) - 1) sc_model++;
`endif
            if (md && !stall && !br) busy_last = cyc + int'(LAT);
        end
        q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; IFIDRegRs = '0; IFIDRegRt = '0; IDUsesRt = 0; IDEXMemRead = 0;
        IDEXRegRt = '0; IDMulDiv = 0; IDReadsHiLo = 0; EXBranchTaken = 0;

        // Reset state
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        idle(2);

        // Load-use on rs: one stall, then the bubble has advanced
        step(0, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0);
        step(0, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 0);
        // rt match but rt not a source: no stall
        step(0, 5'd1, 5'd8, 0, 1, 5'd8, 0, 0, 0);
        // rt match and rt used: stall
        step(0, 5'd1, 5'd8, 1, 1, 5'd8, 0, 0, 0);
        step(0, 5'd1, 5'd8, 1, 0, 5'd0, 0, 0, 0);
        // Load to $0 never stalls
        step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);

        // mult at E0, mfhi waits LAT cycles then advances
        step(0, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0);
        for (int i = 0; i < int'(LAT) + 1; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        idle(1);

        // Branch taken with load-use and a mult in ID: flush, mult never issues
        step(0, 5'd8, 5'd3, 0, 1, 5'd8, 1, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);

        // Flush during MDWAIT keeps the pending result busy
        step(0, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
        for (int i = 0; i < int'(LAT); i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);

        // Simultaneous ld_use and md_use give one stall per cycle
        step(0, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0);
        step(0, 5'd9, 5'd0, 0, 1, 5'd9, 0, 1, 0);
        idle(int'(LAT));

        // Reset mid-MDWAIT clears busy at once; mfhi after release does not stall
        step(0, 5'd4, 5'd5, 1, 0, 5'd0, 1, 0, 0);
        idle(2);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        idle(1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

`ifdef HAZARD_PERF_EN
        // Drive the stall counter into saturation
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0);
        idle(2);
`endif

        idle(2);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
